// File: rtl/uart_pkg.sv
// Shared definitions for the 40-bit UART frame receiver: FSM encodings, framing
// constants and baud timing helpers.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  function automatic int unsigned bit_cyc(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cyc(input int unsigned clk_freq, input int unsigned baud);
    return bit_cyc(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_frame40_if.sv
// Frame-level bus of the 40-bit UART receiver: serial line in, assembled word and
// status strobes out.
interface uart_rx_frame40_if
  import uart_pkg::*;
#(
  parameter int unsigned BYTES = 5
);
  logic                         uart_rx;
  logic [DATA_BITS*BYTES-1:0]   Data;
  logic                         data_valid;
  logic                         frame_err;

  modport master (input uart_rx, output Data, output data_valid, output frame_err);
  modport slave  (output uart_rx, input Data, input data_valid, input frame_err);
endinterface

// File: rtl/uart_rx_byte.sv
// Single-byte UART receiver: synchronizer, edge detect, baud counter and framing FSM.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_ok,
  output logic                 byte_err,
  output logic                 idle,
  output logic                 fall
);

  localparam int unsigned BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int unsigned HALF    = half_cyc(CLK_FREQ, BAUD);
  localparam int unsigned CW      = $clog2(BIT_CYC);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  logic [2:0] sync_q;
  logic       rx_s;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[1:0], uart_rx};
    end
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tick;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  assign tick = (cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    byte_ok   = 1'b0;
    byte_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A start that is no longer low at mid-bit is a glitch, not an error
          if (rx_s != IDLE_LEVEL) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_err_d = ^{shreg_q, rx_s};
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s == IDLE_LEVEL && !par_bad) begin
            byte_ok = 1'b1;
          end else begin
            byte_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  assign rx_byte = shreg_q;
  assign idle    = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_frame40.sv
// 40-bit UART frame receiver: gathers BYTES bytes into one word with inter-byte timeout.
// Define UART_RX_PARITY_EN to receive 8E1 bytes instead of 8N1.
module uart_rx_frame40
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned BYTES        = 5,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  uart_rx_frame40_if.master   bus
);

  localparam int unsigned W       = DATA_BITS * BYTES;
  localparam int unsigned BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int unsigned IW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TO      = TIMEOUT_BITS * BIT_CYC;
  localparam int unsigned GW      = $clog2(TO);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TO - 1);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 byte_ok, byte_err, idle, fall;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .uart_rx  (bus.uart_rx),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .byte_err (byte_err),
    .idle     (idle),
    .fall     (fall)
  );

  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [W-1:0]  data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    data_d     = data_q;
    gap_d      = gap_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (byte_ok) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (byte_idx_q == IW'(i)) asm_d[i*DATA_BITS +: DATA_BITS] = rx_byte;
      end
      if (byte_idx_q == IDX_LAST) begin
        data_d     = asm_d;
        valid_d    = 1'b1;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end else if (byte_err) begin
      err_d      = 1'b1;
      byte_idx_d = '0;
    end

    // A falling edge always beats an expiring gap counter
    if (fall || !idle || byte_idx_q == '0) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      gap_d      = '0;
      err_d      = 1'b1;
      byte_idx_d = '0;
    end else begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
      data_q     <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.Data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_uart_rx_frame40.sv
// Scoreboard bench for uart_rx_frame40, run with a scaled clock of 32 cycles per bit.
module tb_uart_rx_frame40;

  localparam int unsigned CLK_FREQ     = 3_686_400;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned BIT          = CLK_FREQ / BAUD;
  localparam int unsigned BYTES        = 5;
  localparam int unsigned TIMEOUT_BITS = 20;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  uart_rx_frame40_if #(.BYTES(BYTES)) bus ();

  uart_rx_frame40 #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .BYTES        (BYTES),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks   = 0;
  int n_errors   = 0;
  int valid_seen = 0;
  int err_seen   = 0;
  int exp_err    = 0;
  int pushed     = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_wait(input int n);
    repeat (n * int'(BIT)) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic b);
    @(negedge sys_clk);
    bus.uart_rx = b;
    repeat (int'(BIT) - 1) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [39:0] w, input int gap_bits);
    exp_q.push_back(w);
    pushed++;
    for (int i = 0; i < 5; i++) begin
      send_byte(w[i*8 +: 8], 1'b1);
      bit_wait(gap_bits);
    end
  endtask

  always @(negedge sys_clk) begin
    logic [39:0] e;
    logic        have;
    if (bus.data_valid || bus.frame_err)
      check("valid_err_exclusive", 64'(bus.data_valid & bus.frame_err), 64'd0);
    if (bus.frame_err) err_seen++;
    if (bus.data_valid) begin
      valid_seen++;
      have = (exp_q.size() != 0);
      check("sb_has_entry", 64'(have), 64'd1);
      if (have) begin
        e = exp_q.pop_front();
        check("data", 64'(bus.Data), 64'(e));
        last_data = e;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    bus.uart_rx = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("rst_data", 64'(bus.Data), 64'd0);
    check("rst_valid", 64'(bus.data_valid), 64'd0);
    check("rst_err", 64'(bus.frame_err), 64'd0);
    rst_n = 1'b1;
    bit_wait(2);

    // Nominal frame with one idle bit between bytes
    send_frame(40'h10_08_04_02_01, 1);
    bit_wait(2);
    check("nominal_drain", 64'(exp_q.size()), 64'd0);
    check("nominal_no_err", 64'(err_seen), 64'(exp_err));

    // Back-to-back frames, no idle
    send_frame(40'hFF_FF_FF_FF_FF, 0);
    send_frame(40'h00_00_00_00_00, 0);
    bit_wait(2);
    check("b2b_drain", 64'(exp_q.size()), 64'd0);
    check("b2b_valid_count", 64'(valid_seen), 64'd3);

    // Short glitch while idle, shorter than half a bit
    v0 = valid_seen;
    e0 = err_seen;
    @(negedge sys_clk);
    bus.uart_rx = 1'b0;
    repeat (7) @(negedge sys_clk);
    bus.uart_rx = 1'b1;
    bit_wait(2);
    check("glitch_no_valid", 64'(valid_seen), 64'(v0));
    check("glitch_no_err", 64'(err_seen), 64'(e0));
    check("glitch_idle", 64'(dut.u_byte.idle), 64'd1);
    send_frame(40'hC3_5A_00_FF_81, 1);
    bit_wait(2);
    check("glitch_next_drain", 64'(exp_q.size()), 64'd0);

    // Bad stop bit on the third byte
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    exp_err++;
    bit_wait(2);
    check("badstop_err", 64'(err_seen), 64'(exp_err));
    check("badstop_data_hold", 64'(bus.Data), 64'(last_data));
    send_frame(40'hA5_A5_A5_A5_A5, 1);
    bit_wait(2);
    check("badstop_next_drain", 64'(exp_q.size()), 64'd0);

    // Two bytes, then a 25-bit idle gap
    e0 = err_seen;
    send_byte(8'h5E, 1'b1);
    send_byte(8'hE5, 1'b1);
    bit_wait(18);
    check("timeout_not_early", 64'(err_seen), 64'(e0));
    bit_wait(7);
    exp_err++;
    check("timeout_err", 64'(err_seen), 64'(exp_err));
    check("timeout_data_hold", 64'(bus.Data), 64'(last_data));
    send_frame(40'h0F_1E_2D_3C_4B, 1);
    bit_wait(2);
    check("timeout_next_drain", 64'(exp_q.size()), 64'd0);

    // Reset asserted in the middle of byte 4
    e0 = err_seen;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data", 64'(bus.Data), 64'd0);
    check("midrst_valid", 64'(bus.data_valid), 64'd0);
    check("midrst_err", 64'(bus.frame_err), 64'd0);
    repeat (3) @(negedge sys_clk);
    rst_n       = 1'b1;
    bus.uart_rx = 1'b1;
    last_data   = '0;
    bit_wait(12);
    check("midrst_no_pulse", 64'(err_seen), 64'(e0));
    check("midrst_data_zero", 64'(bus.Data), 64'd0);
    send_frame(40'h12_34_56_78_9A, 1);
    bit_wait(2);

    check("final_valid_count", 64'(valid_seen), 64'(pushed));
    check("final_err_count", 64'(err_seen), 64'(exp_err));
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame40.md
Name: uart_rx_frame40

Overview:
- UART receiver, 8N1, LSB-first bits, on a single serial input.
- Assembles five consecutive bytes into one 40-bit word and pulses a valid strobe.
- It is the receive-side counterpart of the 40-bit UART frame transmitter.
- Used on the board's RX pin, or looped back from the transmitter for self-test.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, serial bit rate.
- BYTES, 5, bytes per frame. Data width is 8*BYTES.
- TIMEOUT_BITS, 20, maximum idle gap between bytes of one frame, in bit periods.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial input, idles high, asynchronous to sys_clk.
- Data  output  40  last complete frame. First received byte is Data[7:0]; fifth byte is Data[39:32].
- data_valid  output  1  one-cycle pulse when Data updates.
- frame_err  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (asynchronous, rst_n low): Data=0, data_valid=0, frame_err=0, state IDLE, all counters 0, synchronizer flops=1.
- Reset mid-frame: partial data is lost and no pulse is produced.
- BIT_CYC = CLK_FREQ/BAUD (434 at the defaults). HALF = BIT_CYC/2 (217).
- uart_rx passes through a 2-flop synchronizer. A third flop provides falling-edge detection.
- State machine:
  - IDLE: on a synchronized falling edge, go to START and clear the baud counter.
  - START: at count HALF-1, sample the line. If low, go to DATA with bit_idx=0. If high, treat as a glitch: return to IDLE with no error.
  - DATA: every BIT_CYC cycles after the start mid-point, sample and shift in LSB-first. After bit_idx 7, go to STOP.
  - STOP: sample at mid-bit.
    - High: store the byte into slot byte_idx.
    - Low: assert frame_err for one cycle, clear byte_idx, and go to IDLE without waiting for the line to return high.
    - A new start is accepted only after a fresh falling edge.
- After a good stop bit:
  - If byte_idx < BYTES-1: increment byte_idx and return to IDLE.
  - If byte_idx = BYTES-1: on the cycle after the stop sample, load Data from the assembly register, pulse data_valid, and clear byte_idx.
- Latency: data_valid rises 1 cycle after the 5th stop-bit mid-sample.
- Data holds its value until the next complete frame. Partial frames never alter Data.
- Inter-byte timeout:
  - While IDLE with byte_idx != 0, a gap counter runs.
  - When it reaches TIMEOUT_BITS*BIT_CYC, pulse frame_err for one cycle and clear byte_idx.
  - The gap counter clears on any falling edge.
  - If the timeout and a falling edge occur in the same cycle, the edge wins: no error, and reception continues.
- data_valid and frame_err are never high in the same cycle.
- Counter widths are $clog2 of their maximum value. No wrap-around is possible because each counter clears on state exit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state sits between DATA and STOP and samples one bit at mid-bit.
  - Parity is even: XOR of the 8 data bits and the parity bit must be 0.
  - On a mismatch, frame_err is pulsed after the stop sample, byte_idx clears, and the byte is discarded.
  - The frame is 11 bits per byte.
- Without the macro: there is no PARITY state, and the frame is 10 bits per byte (8N1).

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - functions computing BIT_CYC and HALF from CLK_FREQ and BAUD;
  - the constants DATA_BITS=8 and IDLE_LEVEL=1'b1.
- Sub-module uart_rx_byte contains the synchronizer, state machine, and baud counter. Its outputs are a byte, a byte_ok pulse, and a byte_err pulse.
- The top level holds the byte_idx counter, the assembly register, the timeout counter, and output registers.

Test Plan:
- Nominal: drive 40'h10_08_04_02_01 serially at 115200 baud with LSB byte first and 1 bit of idle between bytes. Required: one data_valid pulse, Data=40'h1008040201, no frame_err.
- Back-to-back frames 40'hFFFFFFFFFF then 40'h0000000000 with zero idle between bytes. Required: two data_valid pulses with the correct values in order.
- Glitch: a 100-cycle low pulse on uart_rx while idle. Required: no pulse on either output, state returns to IDLE, and the next valid frame is received correctly.
- Bad stop bit on the 3rd byte. Required: frame_err pulses once, Data keeps its previous value, and a following full frame 40'hA5A5A5A5A5 is received.
- Send 2 bytes, then idle for 25 bit periods. Required: frame_err pulses after 20 bit periods, and a subsequent full frame is received correctly.
- Assert rst_n low for 3 cycles during byte 4. Required: outputs go to 0 immediately, and a following full frame 40'h123456789A is received correctly.
